// File: rtl/rf_wb_pkg.sv
// Shared definitions for the register-file writeback controller.
//   SEL_W    : register select width (8 registers)
//   DATA_W   : writeback data width
//   NUM_REGS : number of architectural registers tracked by the scoreboard
//   NUM_REQ  : number of writeback requesters (fixed at 2)
//   req_id_e : requester identity used by the arbiter
//   sel_onehot() : decodes a register select to a one-hot register mask
package rf_wb_pkg;

  localparam int unsigned SEL_W    = 3;
  localparam int unsigned DATA_W   = 16;
  localparam int unsigned NUM_REGS = 8;
  localparam int unsigned NUM_REQ  = 2;

  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_LD  = 1'b1
  } req_id_e;

  function automatic logic [NUM_REGS-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
    logic [NUM_REGS-1:0] mask;
    mask      = '0;
    mask[sel] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard for the 8-entry register file.
// Tracks one busy bit per register: a decode reservation sets it, a granted
// writeback clears it, and a set beats a clear on the same register in the
// same cycle. Also produces the decode stall and a sticky protocol error.
// Ports:
//   clk, rst            : clock, synchronous active-low reset
//   set_en, set_sel     : reserve a destination register
//   clr0_en, clr0_sel   : writeback transfer from requester 0
//   clr1_en, clr1_sel   : writeback transfer from requester 1
//   rd1_en/sel, rd2_en/sel : decode source-register reads
//   stall               : a read source has a pending write
//   busy                : registered busy vector
//   err                 : sticky protocol error
module rf_scoreboard
  import rf_wb_pkg::*;
#(
  parameter int unsigned SB_SEL_W    = rf_wb_pkg::SEL_W,
  parameter int unsigned SB_NUM_REGS = rf_wb_pkg::NUM_REGS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   set_en,
  input  logic [SB_SEL_W-1:0]    set_sel,
  input  logic                   clr0_en,
  input  logic [SB_SEL_W-1:0]    clr0_sel,
  input  logic                   clr1_en,
  input  logic [SB_SEL_W-1:0]    clr1_sel,
  input  logic                   rd1_en,
  input  logic [SB_SEL_W-1:0]    rd1_sel,
  input  logic                   rd2_en,
  input  logic [SB_SEL_W-1:0]    rd2_sel,
  output logic                   stall,
  output logic [SB_NUM_REGS-1:0] busy,
  output logic                   err
);

  logic [SB_NUM_REGS-1:0] busy_q, busy_d;
  logic [SB_NUM_REGS-1:0] set_mask, clr_mask;
  logic                   err_q, err_d;
  logic                   err_now;

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_en)  set_mask[set_sel]  = 1'b1;
    if (clr0_en) clr_mask[clr0_sel] = 1'b1;
    if (clr1_en) clr_mask[clr1_sel] = 1'b1;

    // Clear first, then set: a same-cycle reservation keeps the register busy.
    busy_d = (busy_q & ~clr_mask) | set_mask;

    err_now = 1'b0;
    if (clr0_en && !busy_q[clr0_sel]) err_now = 1'b1;
    if (clr1_en && !busy_q[clr1_sel]) err_now = 1'b1;
    // Re-reserving is legal only when the old write retires this same cycle.
    if (set_en && busy_q[set_sel] && !clr_mask[set_sel]) err_now = 1'b1;
    if (clr0_en && clr1_en && (clr0_sel == clr1_sel)) err_now = 1'b1;

    err_d = err_q | err_now;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      busy_q <= '0;
      err_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      err_q  <= err_d;
    end
  end

  // Registered busy only: no combinational path from the writeback inputs.
  assign stall = (rd1_en & busy_q[rd1_sel]) | (rd2_en & busy_q[rd2_sel]);
  assign busy  = busy_q;
  assign err   = err_q;

endmodule

// File: rtl/rf_wb_arbiter.sv
// Writeback controller sharing the register file's single write port between
// the ALU (requester 0) and the load unit (requester 1), with a pending-write
// scoreboard for decode hazard stalls.
// Build option:
//   RF_WB_RR_EN defined   : round-robin arbitration with an rr pointer flop
//   RF_WB_RR_EN undefined : fixed priority, requester 0 wins contention
// Ports:
//   clk, rst                      : clock, synchronous active-low reset
//   wbN_valid/sel/data, wbN_ready : writeback requesters and their grants
//   rsv_valid, rsv_sel            : decode destination reservation
//   rd1_en/sel, rd2_en/sel, stall : decode source reads and hazard stall
//   rf_write/writeregsel/writedata: registered register-file write port
//   busy, err                     : scoreboard vector, sticky protocol error
module rf_wb_arbiter #(
  parameter int unsigned NUM_REQ = rf_wb_pkg::NUM_REQ,
  parameter int unsigned DATA_W  = rf_wb_pkg::DATA_W,
  parameter int unsigned SEL_W   = rf_wb_pkg::SEL_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wb0_valid,
  input  logic [SEL_W-1:0]              wb0_sel,
  input  logic [DATA_W-1:0]             wb0_data,
  output logic                          wb0_ready,
  input  logic                          wb1_valid,
  input  logic [SEL_W-1:0]              wb1_sel,
  input  logic [DATA_W-1:0]             wb1_data,
  output logic                          wb1_ready,
  input  logic                          rsv_valid,
  input  logic [SEL_W-1:0]              rsv_sel,
  input  logic                          rd1_en,
  input  logic [SEL_W-1:0]              rd1_sel,
  input  logic                          rd2_en,
  input  logic [SEL_W-1:0]              rd2_sel,
  output logic                          stall,
  output logic                          rf_write,
  output logic [SEL_W-1:0]              rf_writeregsel,
  output logic [DATA_W-1:0]             rf_writedata,
  output logic [rf_wb_pkg::NUM_REGS-1:0] busy,
  output logic                          err
);

  import rf_wb_pkg::*;

  logic [NUM_REQ-1:0] valid_vec;
  logic [NUM_REQ-1:0] ready_vec;
  logic [NUM_REQ-1:0] xfer_vec;
  req_id_e            pri;
  req_id_e            winner;
  logic               xfer;
  logic [SEL_W-1:0]   grant_sel;
  logic [DATA_W-1:0]  grant_data;

  logic               rf_write_q;
  logic [SEL_W-1:0]   rf_sel_q;
  logic [DATA_W-1:0]  rf_data_q;

`ifdef RF_WB_RR_EN
  req_id_e rr_q, rr_d;
  logic    contested;

  always_comb begin
    contested = rst & wb0_valid & wb1_valid;
    rr_d      = rr_q;
    // Only contested cycles move the pointer, and it lands on the loser.
    if (contested) rr_d = (rr_q == REQ_ALU) ? REQ_LD : REQ_ALU;
  end

  always_ff @(posedge clk) begin
    if (!rst) rr_q <= REQ_ALU;
    else      rr_q <= rr_d;
  end

  assign pri = rr_q;
`else
  assign pri = REQ_ALU;
`endif

  always_comb begin
    valid_vec = {wb1_valid, wb0_valid};
    winner    = REQ_ALU;
    if (valid_vec[REQ_LD] && (!valid_vec[REQ_ALU] || (pri == REQ_LD))) winner = REQ_LD;

    ready_vec = '0;
    // Ready follows valid of the winner only, and is held low during reset.
    if (rst) ready_vec[winner] = valid_vec[winner];

    xfer_vec = valid_vec & ready_vec;
    xfer     = |xfer_vec;

    grant_sel  = wb0_sel;
    grant_data = wb0_data;
    if (xfer_vec[REQ_LD]) begin
      grant_sel  = wb1_sel;
      grant_data = wb1_data;
    end
  end

  assign wb0_ready = ready_vec[REQ_ALU];
  assign wb1_ready = ready_vec[REQ_LD];

  always_ff @(posedge clk) begin
    if (!rst) begin
      rf_write_q <= 1'b0;
      rf_sel_q   <= '0;
      rf_data_q  <= '0;
    end else begin
      rf_write_q <= xfer;
      if (xfer) begin
        rf_sel_q  <= grant_sel;
        rf_data_q <= grant_data;
      end
    end
  end

  assign rf_write       = rf_write_q;
  assign rf_writeregsel = rf_sel_q;
  assign rf_writedata   = rf_data_q;

  rf_scoreboard #(
    .SB_SEL_W    (SEL_W),
    .SB_NUM_REGS (NUM_REGS)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .set_en   (rsv_valid),
    .set_sel  (rsv_sel),
    .clr0_en  (xfer_vec[REQ_ALU]),
    .clr0_sel (wb0_sel),
    .clr1_en  (xfer_vec[REQ_LD]),
    .clr1_sel (wb1_sel),
    .rd1_en   (rd1_en),
    .rd1_sel  (rd1_sel),
    .rd2_en   (rd2_en),
    .rd2_sel  (rd2_sel),
    .stall    (stall),
    .busy     (busy),
    .err      (err)
  );

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: a transaction-level model of the
// writeback port and scoreboard is compared every cycle, plus directed
// literal checks from the test plan.
module tb_rf_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb0_valid, wb1_valid, wb0_ready, wb1_ready;
  logic [2:0]  wb0_sel, wb1_sel, rsv_sel, rd1_sel, rd2_sel, rf_writeregsel;
  logic [15:0] wb0_data, wb1_data, rf_writedata;
  logic        rsv_valid, rd1_en, rd2_en, stall, rf_write, err;
  logic [7:0]  busy;

  int nvec = 0;
  int nmis = 0;
  bit chk_on = 1'b0;

  // Model state
  bit [7:0]  m_busy;
  bit        m_err, m_write, m_rr;
  bit [2:0]  m_sel;
  bit [15:0] m_data;

  always #5 clk = ~clk;

  rf_wb_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .wb0_valid      (wb0_valid),
    .wb0_sel        (wb0_sel),
    .wb0_data       (wb0_data),
    .wb0_ready      (wb0_ready),
    .wb1_valid      (wb1_valid),
    .wb1_sel        (wb1_sel),
    .wb1_data       (wb1_data),
    .wb1_ready      (wb1_ready),
    .rsv_valid      (rsv_valid),
    .rsv_sel        (rsv_sel),
    .rd1_en         (rd1_en),
    .rd1_sel        (rd1_sel),
    .rd2_en         (rd2_en),
    .rd2_sel        (rd2_sel),
    .stall          (stall),
    .rf_write       (rf_write),
    .rf_writeregsel (rf_writeregsel),
    .rf_writedata   (rf_writedata),
    .busy           (busy),
    .err            (err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Grant per the arbitration rules: lone requester wins, else the rr favourite.
  function automatic bit [1:0] exp_grant();
    if (!rst) return 2'b00;
    if (wb0_valid && wb1_valid) return m_rr ? 2'b10 : 2'b01;
    return {wb1_valid, wb0_valid};
  endfunction

  always @(posedge clk) begin
    bit [1:0] g;
    bit [7:0] nb;
    if (!rst) begin
      m_busy = '0; m_err = 0; m_write = 0; m_sel = '0; m_data = '0; m_rr = 0;
    end else begin
      g  = exp_grant();
      nb = m_busy;
      if (g[0]) begin
        if (!m_busy[wb0_sel]) m_err = 1;
        nb[wb0_sel] = 0;
      end
      if (g[1]) begin
        if (!m_busy[wb1_sel]) m_err = 1;
        nb[wb1_sel] = 0;
      end
      if (rsv_valid) begin
        if (m_busy[rsv_sel] && nb[rsv_sel]) m_err = 1;
        nb[rsv_sel] = 1;
      end
      m_write = |g;
      if (g[0]) begin
        m_sel = wb0_sel; m_data = wb0_data;
      end else if (g[1]) begin
        m_sel = wb1_sel; m_data = wb1_data;
      end
`ifdef RF_WB_RR_EN
      if (wb0_valid && wb1_valid) m_rr = !m_rr;
`endif
      m_busy = nb;
    end
  end

  always @(negedge clk) begin
    bit [1:0] g;
    bit       st;
    if (chk_on) begin
      g  = exp_grant();
      st = (rd1_en && m_busy[rd1_sel]) || (rd2_en && m_busy[rd2_sel]);
      chk("m_wb0_ready", 32'(wb0_ready), 32'(g[0]));
      chk("m_wb1_ready", 32'(wb1_ready), 32'(g[1]));
      chk("m_stall", 32'(stall), 32'(st));
      chk("m_rf_write", 32'(rf_write), 32'(m_write));
      chk("m_rf_sel", 32'(rf_writeregsel), 32'(m_sel));
      chk("m_rf_data", 32'(rf_writedata), 32'(m_data));
      chk("m_busy", 32'(busy), 32'(m_busy));
      chk("m_err", 32'(err), 32'(m_err));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic idle();
    wb0_valid = 0; wb1_valid = 0; rsv_valid = 0;
  endtask

  // e1 = 1 when requester 1 is expected to win the contested cycle.
  task automatic contention(input bit e1);
    rsv_valid = 1; rsv_sel = 3'd1;
    cyc();
    rsv_sel = 3'd2;
    cyc();
    rsv_valid = 0;
    wb0_valid = 1; wb0_sel = 3'd1; wb0_data = 16'h1111;
    wb1_valid = 1; wb1_sel = 3'd2; wb1_data = 16'h2222;
    settle();
    chk("cont_ready0", 32'(wb0_ready), 32'(!e1));
    chk("cont_ready1", 32'(wb1_ready), 32'(e1));
    cyc();
    if (e1) wb1_valid = 0;
    else    wb0_valid = 0;
    settle();
    chk("cont_first_sel", 32'(rf_writeregsel), e1 ? 32'd2 : 32'd1);
    chk("cont_first_data", 32'(rf_writedata), e1 ? 32'h2222 : 32'h1111);
    cyc();
    idle();
    settle();
    chk("cont_second_sel", 32'(rf_writeregsel), e1 ? 32'd1 : 32'd2);
    chk("cont_second_data", 32'(rf_writedata), e1 ? 32'h1111 : 32'h2222);
    chk("cont_busy", 32'(busy), 32'h0);
    cyc();
  endtask

  initial begin
    rst = 0;
    wb0_valid = 1; wb0_sel = '0; wb0_data = '0;
    wb1_valid = 1; wb1_sel = '0; wb1_data = '0;
    rsv_valid = 0; rsv_sel = '0;
    rd1_en = 0; rd1_sel = '0; rd2_en = 0; rd2_sel = '0;

    // Reset held two cycles with both requesters asking
    cyc();
    chk_on = 1;
    settle();
    chk("rst_ready0", 32'(wb0_ready), 32'h0);
    chk("rst_ready1", 32'(wb1_ready), 32'h0);
    cyc();
    settle();
    chk("rst_rf_write", 32'(rf_write), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    cyc();
    rst = 1;
    idle();

    // Single write through the load unit
    rsv_valid = 1; rsv_sel = 3'd3;
    cyc();
    rsv_valid = 0;
    wb1_valid = 1; wb1_sel = 3'd3; wb1_data = 16'hBEEF;
    settle();
    chk("single_ready1", 32'(wb1_ready), 32'h1);
    chk("single_busy_pre", 32'(busy), 32'h08);
    cyc();
    idle();
    settle();
    chk("single_rf_write", 32'(rf_write), 32'h1);
    chk("single_rf_sel", 32'(rf_writeregsel), 32'd3);
    chk("single_rf_data", 32'(rf_writedata), 32'hBEEF);
    chk("single_busy_post", 32'(busy), 32'h0);
    cyc();

    // Contention twice: rr flips to requester 1 only with the round-robin build
    contention(1'b0);
`ifdef RF_WB_RR_EN
    contention(1'b1);
`else
    contention(1'b0);
`endif

    // Hazard on R5; the reserving cycle itself does not stall
    rsv_valid = 1; rsv_sel = 3'd5;
    rd1_en = 1; rd1_sel = 3'd5;
    settle();
    chk("haz_stall_t0", 32'(stall), 32'h0);
    cyc();
    rsv_valid = 0;
    settle();
    chk("haz_stall_t1", 32'(stall), 32'h1);
    cyc();
    wb0_valid = 1; wb0_sel = 3'd5; wb0_data = 16'h5555;
    settle();
    chk("haz_stall_xfer", 32'(stall), 32'h1);
    cyc();
    idle();
    settle();
    chk("haz_stall_wr", 32'(stall), 32'h0);
    chk("haz_rf_write", 32'(rf_write), 32'h1);
    chk("haz_rf_data", 32'(rf_writedata), 32'h5555);
    cyc();
    rd1_en = 0;

    // Same-cycle clear and set on R4
    rsv_valid = 1; rsv_sel = 3'd4;
    cyc();
    wb0_valid = 1; wb0_sel = 3'd4; wb0_data = 16'h4444;
    cyc();
    idle();
    rd2_en = 1; rd2_sel = 3'd4;
    settle();
    chk("setclr_busy4", 32'(busy[4]), 32'h1);
    chk("setclr_err", 32'(err), 32'h0);
    chk("setclr_stall", 32'(stall), 32'h1);
    cyc();
    rd2_en = 0;
    wb0_valid = 1;
    cyc();
    idle();
    cyc();

    // Writeback to unreserved R6 raises a sticky error
    wb0_valid = 1; wb0_sel = 3'd6; wb0_data = 16'h6666;
    cyc();
    idle();
    settle();
    chk("err_set", 32'(err), 32'h1);
    cyc();
    cyc();
    settle();
    chk("err_sticky", 32'(err), 32'h1);

    // Reset with a write pending and a reservation outstanding
    rsv_valid = 1; rsv_sel = 3'd7;
    cyc();
    rsv_valid = 0;
    wb1_valid = 1; wb1_sel = 3'd7; wb1_data = 16'h7777;
    rsv_valid = 1; rsv_sel = 3'd2;
    cyc();
    idle();
    rst = 0;
    wb0_valid = 1;
    settle();
    chk("midrst_rf_write", 32'(rf_write), 32'h1);
    chk("midrst_ready0", 32'(wb0_ready), 32'h0);
    cyc();
    rst = 1;
    idle();
    settle();
    chk("midrst_rf_clear", 32'(rf_write), 32'h0);
    chk("midrst_busy", 32'(busy), 32'h0);
    chk("midrst_err", 32'(err), 32'h0);
    cyc();
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Writeback controller for the 8×16 register file. It shares the file's single write port between two writeback requesters: requester 0 is the ALU and requester 1 is the load unit. It also keeps a pending-write scoreboard, so decode can stall on read-after-write hazards. It sits between the execute/memory stages and the register file's `write`/`writeregsel`/`writedata` inputs.

## Interface
Parameters:
- `NUM_REQ`, 2: number of writeback requesters; the value is fixed at 2.
- `DATA_W`, 16: writeback data width.
- `SEL_W`, 3: register select width, giving 8 registers.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-low reset: sampled on the rising edge of `clk`, and state clears when `rst`==0.
- `wb0_valid`, `wb1_valid`  in  1  requester has a writeback pending.
- `wb0_sel`, `wb1_sel`  in  SEL_W  destination register.
- `wb0_data`, `wb1_data`  in  DATA_W  writeback value.
- `wb0_ready`, `wb1_ready`  out  1  grant; a transfer occurs when valid & ready.
- `rsv_valid`  in  1  decode reserves a destination register.
- `rsv_sel`  in  SEL_W  register to reserve.
- `rd1_en`, `rd2_en`  in  1  decode reads the source register.
- `rd1_sel`, `rd2_sel`  in  SEL_W  source registers.
- `stall`  out  1  a source register has a write pending.
- `rf_write`  out  1  register-file write enable.
- `rf_writeregsel`  out  SEL_W  register-file write select.
- `rf_writedata`  out  DATA_W  register-file write data.
- `busy`  out  8  scoreboard, one bit per register.
- `err`  out  1  sticky protocol error.

## Operation
- **Arbitration (combinational):**
  - If exactly one `wbN_valid` is high, that requester is granted.
  - If both are high, the round-robin pointer `rr` picks the winner; the loser sees ready=0 and must hold its valid, sel and data stable.
  - `wbN_ready` is never high while `wbN_valid` is low.
- **Round-robin pointer:**
  - Toggles only on a contested cycle, and then points at the loser.
  - Uncontested grants leave `rr` unchanged.
- **Output register:**
  - On a transfer, the granted sel/data are captured, and `rf_write`=1 in the following cycle.
  - With no transfer, `rf_write`=0, and sel/data hold their last values.
- **Scoreboard:**
  - `rsv_valid` sets `busy[rsv_sel]` at the edge.
  - A transfer clears `busy[wbN_sel]` at the same edge.
  - If a clear and a set hit the same register in the same cycle, the set wins: the result is busy=1.
- **Stall:** `stall` = (`rd1_en` & `busy[rd1_sel]`) | (`rd2_en` & `busy[rd2_sel]`), computed from registered `busy`.
  - A busy bit clears in the same cycle `rf_write` presents the data.
  - The register file's write-to-read bypass then supplies the value to a reader unstalled in that cycle.
- **Error (`err` goes to 1 and stays until reset) when any of the following occurs:**
  - A transfer to a register that is not busy.
  - A reservation of a register that is already busy, unless that register is being cleared in the same cycle.
  - Both requesters transferring to the same register in one cycle. This cannot happen, because only one requester is granted per cycle.

## Timing
- Reset values: `rf_write`=0, `rf_writeregsel`=0, `rf_writedata`=0, `busy`=0, `err`=0, `rr`=0 (requester 0 is favoured first), `stall`=0.
- Grant to register-file write latency: 1 cycle. Throughput: one writeback per cycle.
- `wbN_ready` and `stall` are combinational from inputs and registered state. There is no combinational path from `wbN_*` to `stall`.
- Reset mid-operation:
  - The pending `rf_write` is dropped; the register file itself is reset the same cycle.
  - All reservations are lost.
  - During reset, `wbN_ready` is forced to 0.
- `rsv_valid` on cycle t affects `stall` from cycle t+1.

## Configuration
- **`RF_WB_RR_EN` defined:** round-robin arbitration as described, with the `rr` flop present.
- **Not defined:** fixed priority; requester 0 always wins a contested cycle, and no `rr` flop exists. All other behaviour is identical.

## Structure
- **Package `rf_wb_pkg`:**
  - `SEL_W`, `DATA_W`, `NUM_REGS`=8.
  - Requester id enum `REQ_ALU`=0, `REQ_LD`=1.
- **Sub-module `rf_scoreboard`:** the busy vector plus the set/clear/priority logic, the stall lookup and the error checks.
- The top level holds the arbiter, the `rr` flop and the output register.

## Test plan
- **Reset:** hold `rst`=0 for 2 cycles with both valids high → `wb0_ready`=`wb1_ready`=0, `rf_write`=0, `busy`=0, `err`=0.
- **Single write:**
  - Stimulus: reserve R3; next cycle `wb1_valid`, sel=3, data=0xBEEF.
  - Required response: `wb1_ready`=1, then next cycle `rf_write`=1, `rf_writeregsel`=3, `rf_writedata`=0xBEEF, `busy[3]`=0.
- **Contention:**
  - Stimulus: reserve R1 and R2; both valid (wb0→R1 0x1111, wb1→R2 0x2222) with `rr`=0.
  - Required response: R1 is written first, then R2 the next cycle.
  - Repeat the contention: requester 1 now wins. Without `RF_WB_RR_EN`, requester 0 wins both times.
- **Hazard:**
  - Stimulus: reserve R5; `rd1_en`=1, `rd1_sel`=5.
  - Required response: `stall`=1 until the transfer edge, then 0 in the `rf_write` cycle.
- **Same-cycle set/clear:** wb0 transfers to R4 while `rsv_sel`=4 → `busy[4]`=1 afterwards and `err`=0.
- **Errors:** writeback to unreserved R6 → `err`=1 the next cycle, staying 1 until `rst`=0.
